// File: rtl/fifo36e2_if.sv
// Handshake and status bundle for fifo36e2: write/read requests, data paths,
// occupancy flags and raw pointers.
interface fifo36e2_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int PARITY_WIDTH = 8,
    parameter int FIFO_DEPTH   = 512
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]   DIN;
    logic [PARITY_WIDTH-1:0] DINP;
    logic                    WREN;
    logic                    RDEN;
    logic [DATA_WIDTH-1:0]   DOUT;
    logic [PARITY_WIDTH-1:0] DOUTP;
    logic                    EMPTY;
    logic                    FULL;
    logic                    PROGFULL;
    logic                    PROGEMPTY;
    logic [AW-1:0]           WRCOUNT;
    logic [AW-1:0]           RDCOUNT;
    logic                    WRERR;
    logic                    RDERR;

    modport master (
        output DIN, DINP, WREN, RDEN,
        input  DOUT, DOUTP, EMPTY, FULL, PROGFULL, PROGEMPTY,
               WRCOUNT, RDCOUNT, WRERR, RDERR
    );

    modport slave (
        input  DIN, DINP, WREN, RDEN,
        output DOUT, DOUTP, EMPTY, FULL, PROGFULL, PROGEMPTY,
               WRCOUNT, RDCOUNT, WRERR, RDERR
    );
endinterface

// File: rtl/fifo36e2.sv
// Single-clock FIFO with side-band data, programmable flags and error pulses.
// Define FIFO36E2_FWFT_EN for first-word-fall-through output; default is standard read.
module fifo36e2 #(
    parameter int DATA_WIDTH        = 64,
    parameter int PARITY_WIDTH      = 8,
    parameter int FIFO_DEPTH        = 512,
    parameter int PROG_FULL_THRESH  = 256,
    parameter int PROG_EMPTY_THRESH = 256
) (
    input logic       clk,
    input logic       rst_n,
    fifo36e2_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_WIDTH + PARITY_WIDTH;

    localparam logic [AW:0]   DEPTH_LVL = FIFO_DEPTH;
    localparam logic [AW:0]   PF_LVL    = PROG_FULL_THRESH;
    localparam logic [AW:0]   PE_LVL    = PROG_EMPTY_THRESH;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          wr_ok;
    logic          rd_ok;
    logic [WW-1:0] head;
    logic [WW-1:0] out_q;
    logic [WW-1:0] shown;
    logic          wr_err;
    logic          rd_err;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_LVL);
    assign wr_ok = bus.WREN && !full;
    assign rd_ok = bus.RDEN && !empty;
    assign head  = mem[rd_ptr];

    // Storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {bus.DIN, bus.DINP};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Rejected requests pulse for exactly the cycle after the offending edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            wr_err <= bus.WREN && full;
            rd_err <= bus.RDEN && empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (rd_ok) begin
            out_q <= head;
        end
    end

    // In fall-through mode out_q only keeps the last acknowledged word for the empty case.
`ifdef FIFO36E2_FWFT_EN
    assign shown = empty ? out_q : head;
`else
    assign shown = out_q;
`endif

    assign bus.DOUT      = shown[WW-1:PARITY_WIDTH];
    assign bus.DOUTP     = shown[PARITY_WIDTH-1:0];
    assign bus.EMPTY     = empty;
    assign bus.FULL      = full;
    assign bus.PROGFULL  = (count >= PF_LVL);
    assign bus.PROGEMPTY = (count <= PE_LVL);
    assign bus.WRCOUNT   = wr_ptr;
    assign bus.RDCOUNT   = rd_ptr;
    assign bus.WRERR     = wr_err;
    assign bus.RDERR     = rd_err;
endmodule

// File: tb/tb_fifo36e2.sv
// Scoreboard bench for fifo36e2: driver predicts read data into a queue,
// a monitor pops and compares whenever the FIFO presents a read word.
module tb_fifo36e2;
    localparam int DW    = 64;
    localparam int PW    = 8;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo36e2_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .FIFO_DEPTH(DEPTH)) bus ();

    fifo36e2 #(
        .DATA_WIDTH(DW),
        .PARITY_WIDTH(PW),
        .FIFO_DEPTH(DEPTH),
        .PROG_FULL_THRESH(256),
        .PROG_EMPTY_THRESH(256)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [DW+PW-1:0] model_q[$];
    logic [DW+PW-1:0] exp_q[$];
    int               m_count      = 0;
    logic [AW-1:0]    m_wptr       = '0;
    logic [AW-1:0]    m_rptr       = '0;
    logic             m_wrerr      = 1'b0;
    logic             m_rderr      = 1'b0;
    int               rd_fire_cnt  = 0;
    int               rd_check_cnt = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] sideOf(input logic [DW-1:0] d);
        return d[PW-1:0] ^ 8'h5A;
    endfunction

    // One clock of stimulus; the model advances only after the edge it predicts.
    task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d);
        logic wr_ok;
        logic rd_ok;
        @(negedge clk);
        #1;
        bus.WREN = w;
        bus.RDEN = r;
        bus.DIN  = d;
        bus.DINP = sideOf(d);
        wr_ok = w && (m_count < DEPTH);
        rd_ok = r && (m_count > 0);
        if (rd_ok) begin
            exp_q.push_back(model_q[0]);
`ifdef FIFO36E2_FWFT_EN
            rd_fire_cnt++;
`endif
        end
        @(posedge clk);
        #1;
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back({d, sideOf(d)});
        m_count = model_q.size();
        if (wr_ok) m_wptr++;
        if (rd_ok) m_rptr++;
        m_wrerr = w && !wr_ok;
        m_rderr = r && !rd_ok;
`ifndef FIFO36E2_FWFT_EN
        if (rd_ok) rd_fire_cnt++;
`endif
        bus.WREN = 1'b0;
        bus.RDEN = 1'b0;
    endtask

    task automatic resetModel();
        model_q.delete();
        exp_q.delete();
        m_count      = 0;
        m_wptr       = '0;
        m_rptr       = '0;
        m_wrerr      = 1'b0;
        m_rderr      = 1'b0;
        rd_check_cnt = rd_fire_cnt;
    endtask

    // Monitor: status every cycle, read data whenever a read has been presented.
    initial begin
        logic [DW+PW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            checkOutput("flags", {bus.EMPTY, bus.FULL, bus.PROGEMPTY, bus.PROGFULL, bus.WRERR, bus.RDERR},
                        {m_count == 0, m_count == DEPTH, m_count <= 256, m_count >= 256, m_wrerr, m_rderr});
            checkOutput("pointers", {bus.WRCOUNT, bus.RDCOUNT}, {m_wptr, m_rptr});
            while (rd_check_cnt < rd_fire_cnt) begin
                rd_check_cnt++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("read_data", {bus.DOUT, bus.DOUTP}, e);
                end
            end
        end
    end

    initial begin
        bus.WREN = 1'b0;
        bus.RDEN = 1'b0;
        bus.DIN  = '0;
        bus.DINP = '0;
        #3;
        checkOutput("reset_empty", bus.EMPTY, 1);
        checkOutput("reset_full", bus.FULL, 0);
        checkOutput("reset_progempty", bus.PROGEMPTY, 1);
        checkOutput("reset_progfull", bus.PROGFULL, 0);
        checkOutput("reset_wrcount", bus.WRCOUNT, 0);
        checkOutput("reset_rdcount", bus.RDCOUNT, 0);
        checkOutput("reset_dout", {bus.DOUT, bus.DOUTP}, 0);
        checkOutput("reset_errs", {bus.WRERR, bus.RDERR}, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Read on empty FIFO
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("empty_read_rderr", bus.RDERR, 1);
        checkOutput("empty_read_rdcount", bus.RDCOUNT, 0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("rderr_one_cycle", bus.RDERR, 0);

        // Three words in, three out
        applyStimulus(1'b1, 1'b0, 64'h11);
        checkOutput("first_write_empty", bus.EMPTY, 0);
`ifdef FIFO36E2_FWFT_EN
        checkOutput("fwft_first_word", bus.DOUT, 64'h11);
`else
        checkOutput("std_dout_holds", bus.DOUT, 64'h0);
`endif
        applyStimulus(1'b1, 1'b0, 64'h22);
        applyStimulus(1'b1, 1'b0, 64'h33);
        repeat (3) applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("drained_empty", bus.EMPTY, 1);
        checkOutput("dout_holds_last", {bus.DOUT, bus.DOUTP}, {64'h33, 8'h69});

        // Fill to capacity
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h1000 + 64'(i));
            if (i == 254) checkOutput("progfull_255", bus.PROGFULL, 0);
            if (i == 255) checkOutput("progfull_256", bus.PROGFULL, 1);
            if (i == 510) checkOutput("full_511", bus.FULL, 0);
            if (i == 511) checkOutput("full_512", bus.FULL, 1);
        end
        applyStimulus(1'b1, 1'b0, 64'hDEAD);
        checkOutput("overflow_wrerr", bus.WRERR, 1);
        checkOutput("overflow_wrcount", bus.WRCOUNT, 9'd3);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("wrerr_one_cycle", bus.WRERR, 0);

        // Full with both requests: only the read proceeds
        applyStimulus(1'b1, 1'b1, 64'hBEEF);
        checkOutput("full_both_wrerr", bus.WRERR, 1);
        checkOutput("full_both_notfull", bus.FULL, 0);
        repeat (DEPTH - 1) applyStimulus(1'b0, 1'b1, '0);
        checkOutput("full_drain_empty", bus.EMPTY, 1);
        checkOutput("full_drain_last", bus.DOUT, 64'h11FF);

        // Empty with both requests: only the write proceeds
        applyStimulus(1'b1, 1'b1, 64'hCAFE);
        checkOutput("empty_both_rderr", bus.RDERR, 1);
        checkOutput("empty_both_stored", bus.EMPTY, 0);
        applyStimulus(1'b0, 1'b1, '0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, 64'h2000 + 64'(i));
        #2 rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midreset_empty", bus.EMPTY, 1);
        checkOutput("midreset_wrcount", bus.WRCOUNT, 0);
        checkOutput("midreset_rdcount", bus.RDCOUNT, 0);
        checkOutput("midreset_dout", bus.DOUT, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'h3000);
        applyStimulus(1'b0, 1'b1, '0);

        // Random streaming: write-heavy then read-heavy to hit both ends and wrap
        for (int i = 0; i < 2000; i++) begin
            logic w;
            logic r;
            w = (i < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus(w, r, {$urandom, $urandom});
        end
        repeat (DEPTH + 4) applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo36e2.md
FIFO36E2 -- requirements
Module: fifo36e2

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of DIN/DOUT data field.
REQ-002 Parameter PARITY_WIDTH, default 8, width of DINP/DOUTP side field (0 not allowed; min 1).
REQ-003 Parameter FIFO_DEPTH, default 512, word capacity, power of two, >= 4.
REQ-004 Parameter PROG_FULL_THRESH, default 256, programmable-full level in words.
REQ-005 Parameter PROG_EMPTY_THRESH, default 256, programmable-empty level in words.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 DIN  input  DATA_WIDTH  write data.
REQ-010 DINP  input  PARITY_WIDTH  write side data, stored alongside DIN.
REQ-011 WREN  input  1  write request.
REQ-012 RDEN  input  1  read request.
REQ-013 DOUT  output  DATA_WIDTH  read data.
REQ-014 DOUTP  output  PARITY_WIDTH  read side data.
REQ-015 EMPTY  output  1  no word available.
REQ-016 FULL  output  1  FIFO_DEPTH words stored.
REQ-017 PROGFULL / PROGEMPTY  output  1 each  programmable flags.
REQ-018 WRCOUNT / RDCOUNT  output  $clog2(FIFO_DEPTH) each  raw write / read pointers.
REQ-019 WRERR / RDERR  output  1 each  rejected-write / rejected-read pulses.

Function
REQ-020 Occupancy counter 0..FIFO_DEPTH; all FIFO_DEPTH entries usable (no wasted slot).
REQ-021 EMPTY = (count==0); FULL = (count==FIFO_DEPTH); both combinational from registered count.
REQ-022 Write accepted at edge iff WREN=1 and FULL=0 before edge: {DIN,DINP} stored at WRCOUNT, WRCOUNT increments modulo FIFO_DEPTH.
REQ-023 Read accepted at edge iff RDEN=1 and EMPTY=0 before edge: RDCOUNT increments modulo FIFO_DEPTH.
REQ-024 WREN=1 while FULL=1: write dropped, WRERR=1 for the following cycle only; likewise RDEN=1 while EMPTY=1 drops read, RDERR=1 next cycle only.
REQ-025 Simultaneous WREN/RDEN: each judged independently against pre-edge flags; when FULL only read proceeds (WRERR pulses); when EMPTY only write proceeds (RDERR pulses); otherwise both proceed, count unchanged.
REQ-026 Latency: word written at edge N makes EMPTY=0 after edge N.
REQ-027 PROGFULL = (count >= PROG_FULL_THRESH); PROGEMPTY = (count <= PROG_EMPTY_THRESH).
REQ-028 When EMPTY=1, DOUT/DOUTP hold the last word presented (0 after reset), never stale memory.
REQ-029 Data emerges in write order; pointers wrap seamlessly at FIFO_DEPTH.

Reset
REQ-030 rst_n=0 asynchronously clears pointers, count, DOUT, DOUTP, WRERR, RDERR to 0; EMPTY=1, FULL=0, PROGEMPTY=1, PROGFULL=0.
REQ-031 Reset mid-operation discards all stored words; memory contents need not be cleared.
REQ-032 First accepted write is the first edge with rst_n=1.

Configuration
REQ-033 Macro FIFO36E2_FWFT_EN defined: first-word-fall-through; DOUT/DOUTP show the head word whenever EMPTY=0, RDEN acknowledges it and next word appears after that edge.
REQ-034 FIFO36E2_FWFT_EN undefined: standard mode; accepted read loads head word into DOUT/DOUTP register after the edge; DOUT holds otherwise.

Verification
REQ-035 Reset, write 0x11,0x22,0x33 -> (FWFT) DOUT=0x11 one cycle after first write; three reads return 0x11,0x22,0x33; EMPTY=1 after, DOUT holds 0x33.
REQ-036 Write 512 words -> FULL=1 after 512th write, PROGFULL=1 from 256th; 513th write -> WRERR one-cycle pulse, contents unchanged.
REQ-037 RDEN=1 on empty FIFO -> RDERR pulse, RDCOUNT stays 0.
REQ-038 Full FIFO, WREN=RDEN=1 -> one word read, write dropped, WRERR=1; empty FIFO, both high -> write stored, RDERR=1, count=1.
REQ-039 Fill 300 words, assert rst_n=0 mid-cycle -> EMPTY=1, WRCOUNT=RDCOUNT=0, DOUT=0 immediately.
REQ-040 Stream 2000 words with random WREN/RDEN -> output order matches scoreboard across pointer wrap, both macro settings.
